sram_bank_arbiter: RTL and testbench
====================================

// Module: sram_bank_arbiter
// PURPOSE
//  Shares the multi-bank SRAM array between NUM_REQ requesters (DMA loader, compute read, writeback).
//  Each cycle, every bank independently picks one requester by round-robin; banks run in parallel.
//  Drives the flat en/we/addr/data_in buses of the SRAM array and returns read data to the winner.
//  Fixed pipeline latency; sits between the NPU engines and the SRAM array.
// PARAMETERS
//  NUM_REQ   3   number of requesters
//  NUM_BANKS 4   number of SRAM banks (top level sets this to NUM_SRAMS)
//  ADDR_W    16  per-bank address width (top level sets this to MAX_ADDR_WIDTH)
//  DATA_W    64  per-bank write data width (top level sets this to MAX_DATA_WIDTH)
//  RDATA_W   64  per-bank read data width (top level sets this to SRAM_WIDTH_O)
//  BANK_W    derived, max(1,$clog2(NUM_BANKS)); localparam, not overridable
// PORTS
//  clk        in   1                  single clock; all logic on posedge
//  rst        in   1                  synchronous reset, active-low (0 = reset)
//  req_valid  in   NUM_REQ            request valid, one bit per requester
//  req_ready  out  NUM_REQ            grant; a transfer occurs when valid & ready
//  req_we     in   NUM_REQ            1 = write, 0 = read
//  req_bank   in   NUM_REQ*BANK_W     target bank index
//  req_addr   in   NUM_REQ*ADDR_W     word address within the bank
//  req_wdata  in   NUM_REQ*DATA_W     write data
//  rsp_valid  out  NUM_REQ            read data valid pulse; no backpressure
//  rsp_err    out  NUM_REQ            with rsp_valid: the bank index was out of range
//  rsp_rdata  out  NUM_REQ*RDATA_W    read data; zero when rsp_err is set
//  sram_en    out  NUM_BANKS          to SRAM array en
//  sram_we    out  NUM_BANKS          to SRAM array we
//  sram_addr  out  NUM_BANKS*ADDR_W   to SRAM array addr
//  sram_wdata out  NUM_BANKS*DATA_W   to SRAM array data_in
//  sram_rdata in   NUM_BANKS*RDATA_W  from SRAM array data_out; valid 1 cycle after en
// BEHAVIOUR
//  Reset (rst==0 at posedge): sram_en/we/addr/wdata = 0; rsp_valid/err/rdata = 0.
//    All RR pointers = 0; in-flight reads are dropped, with no response.
//  req_ready is combinational from req_valid, req_bank and the RR pointers. It is forced to 0 while rst==0.
//  Arbitration, per bank b:
//    Candidates are requesters r with req_valid[r] and req_bank[r]==b.
//    Winner is the first candidate at or after ptr[b], wrapping modulo NUM_REQ.
//    ptr[b] <= winner+1 (mod NUM_REQ) only when bank b grants. Otherwise ptr[b] holds.
//  Each requester targets one bank, so it is granted at most once per cycle.
//    Losers see ready=0 and must hold all request fields stable.
//  Issue (cycle T accept): at T+1, sram_en[b]=1 and sram_we/addr/wdata carry the winner's fields (registered).
//    Banks with no grant at T have sram_en[b]=0 at T+1; addr/wdata hold their last value.
//  Read return: at T+2, rsp_valid[r]=1 and rsp_rdata[r] = sram_rdata[b] (combinational from the bank output).
//    Total read latency is 2 cycles. Writes produce no response.
//  A per-bank 2-stage tag pipe {valid, req_id} routes each response.
//    Two banks never return to the same requester in the same cycle; by construction it issues at most once per cycle.
//  Out-of-range bank (req_bank >= NUM_BANKS): granted immediately (ready=1) and never reaches the SRAM.
//    A read gets rsp_valid=1, rsp_err=1, rdata=0 at T+2. A write is silently dropped.
//  Back-to-back: a requester may issue every cycle. Its responses return in issue order (fixed latency).
//  Reset mid-operation: any response due in the cycle after reset deasserts is suppressed.
// STRUCTURE
//  Shared constants (NUM_SRAMS, MAX_ADDR_WIDTH, MAX_DATA_WIDTH, SRAM_WIDTH_O) come from params.vh.
//  Submodule rr_arbiter #(N=NUM_REQ): one instance per bank, via a generate loop.
//    Ports: clk, rst, req[N], adv, grant[N] (one-hot), with an internal pointer.
//  Top level handles request decode, output mux/registers and the response tag pipe.
// TESTING
//  1 Reset: hold rst=0 with all req_valid=1 -> req_ready=0, sram_en=0, rsp_valid=0 throughout.
//  2 Single read: r0 reads bank2 addr 0x10 (preloaded 0xAB) -> sram_en[2]=1 at T+1, rsp_valid[0]=1, rdata=0xAB at T+2.
//  3 Conflict: r0,r1,r2 all hold read valid on bank1 for 6 cycles -> grants r0,r1,r2,r0,r1,r2, each response at +2.
//  4 Parallel: r0 writes b0, r1 writes b1, r2 reads b3 in the same cycle -> all ready=1; en=4'b1011 at T+1.
//  5 Bad bank: NUM_BANKS=3, r1 reads bank 3 -> ready=1, no sram_en; rsp_valid[1]=1, rsp_err[1]=1, rdata=0 at T+2.
//  6 Mid-op reset: issue 2 reads, then assert rst at T+1 -> no rsp_valid afterwards; the first post-reset grant goes to r0.

Source files
------------

// File: rtl/sram_bank_arbiter_pkg.sv
// ============================================================================
// sram_bank_arbiter_pkg
// Shared SRAM geometry constants and index-width helper for the bank arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sram_bank_arbiter_pkg;

   localparam int NUM_SRAMS      = 4;
   localparam int MAX_ADDR_WIDTH = 16;
   localparam int MAX_DATA_WIDTH = 64;
   localparam int SRAM_WIDTH_O   = 64;

   // Index width that never collapses to zero for single-entry sets.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sram_bank_arbiter_if.sv
// ============================================================================
// sram_bank_arbiter_if
// Requester-side request/response bus of the SRAM bank arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sram_bank_arbiter_if
   import sram_bank_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int NUM_BANKS = NUM_SRAMS,
   parameter int ADDR_W    = MAX_ADDR_WIDTH,
   parameter int DATA_W    = MAX_DATA_WIDTH,
   parameter int RDATA_W   = SRAM_WIDTH_O
);
   localparam int BANK_W = idx_width(NUM_BANKS);

   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ-1:0]         req_we;
   logic [NUM_REQ*BANK_W-1:0]  req_bank;
   logic [NUM_REQ*ADDR_W-1:0]  req_addr;
   logic [NUM_REQ*DATA_W-1:0]  req_wdata;
   logic [NUM_REQ-1:0]         rsp_valid;
   logic [NUM_REQ-1:0]         rsp_err;
   logic [NUM_REQ*RDATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_bank, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_bank, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_err, rsp_rdata
   );

endinterface

`default_nettype wire

// File: rtl/sram_bank_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter
// Round-robin one-hot arbiter; pointer moves past the winner when adv is set.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
   import sram_bank_arbiter_pkg::*;
#(
   parameter int N = 3
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         adv,
   output logic [N-1:0] grant
);
   localparam int PTR_W = idx_width(N);

   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_win;
   logic [N-1:0]     w_mask;
   logic [N-1:0]     w_pick;
   logic             w_found;

   // Prefer requesters at or above the pointer; fall back to the lowest one.
   always_comb begin
      w_mask  = '0;
      grant   = '0;
      w_win   = '0;
      w_found = 1'b0;
      for (int i = 0; i < N; i++)
         w_mask[i] = (i >= int'(r_ptr));
      w_pick = (|(req & w_mask)) ? (req & w_mask) : req;
      for (int i = 0; i < N; i++) begin
         if (!w_found && w_pick[i]) begin
            w_found  = 1'b1;
            grant[i] = 1'b1;
            w_win    = PTR_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         r_ptr <= '0;
      else if (adv && w_found)
         r_ptr <= (w_win == PTR_W'(N - 1)) ? '0 : w_win + 1'b1;
   end

endmodule

`default_nettype wire

// File: rtl/sram_bank_arbiter.sv
// ============================================================================
// sram_bank_arbiter
// Per-bank round-robin sharing of the SRAM array with fixed 2-cycle read return.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_bank_arbiter
   import sram_bank_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int NUM_BANKS = NUM_SRAMS,
   parameter int ADDR_W    = MAX_ADDR_WIDTH,
   parameter int DATA_W    = MAX_DATA_WIDTH,
   parameter int RDATA_W   = SRAM_WIDTH_O
)(
   input  logic                         clk,
   input  logic                         rst,
   sram_bank_arbiter_if.slave           bus,
   output logic [NUM_BANKS-1:0]         sram_en,
   output logic [NUM_BANKS-1:0]         sram_we,
   output logic [NUM_BANKS*ADDR_W-1:0]  sram_addr,
   output logic [NUM_BANKS*DATA_W-1:0]  sram_wdata,
   input  logic [NUM_BANKS*RDATA_W-1:0] sram_rdata
);
   localparam int BANK_W = idx_width(NUM_BANKS);
   localparam int ID_W   = idx_width(NUM_REQ);

   logic [NUM_REQ-1:0]         w_in_range;
   logic [NUM_REQ-1:0]         w_bank_req  [NUM_BANKS];
   logic [NUM_REQ-1:0]         w_bank_gnt  [NUM_BANKS];
   logic [NUM_BANKS-1:0]       w_bank_adv;
   logic [NUM_REQ-1:0]         w_granted;
   logic [ID_W-1:0]            w_win_id    [NUM_BANKS];
   logic                       w_win_we    [NUM_BANKS];
   logic [ADDR_W-1:0]          w_win_addr  [NUM_BANKS];
   logic [DATA_W-1:0]          w_win_wdata [NUM_BANKS];
   logic [NUM_REQ-1:0]         w_rsp_valid;
   logic [NUM_REQ*RDATA_W-1:0] w_rsp_rdata;

   logic [NUM_BANKS-1:0]        r_en;
   logic [NUM_BANKS-1:0]        r_we;
   logic [NUM_BANKS*ADDR_W-1:0] r_addr;
   logic [NUM_BANKS*DATA_W-1:0] r_wdata;
   logic [NUM_BANKS-1:0]        r_tag1_v;
   logic [NUM_BANKS-1:0]        r_tag2_v;
   logic [ID_W-1:0]             r_tag1_id [NUM_BANKS];
   logic [ID_W-1:0]             r_tag2_id [NUM_BANKS];
   logic [NUM_REQ-1:0]          r_err1;
   logic [NUM_REQ-1:0]          r_err2;

   always_comb begin
      for (int r = 0; r < NUM_REQ; r++)
         w_in_range[r] = int'(bus.req_bank[r*BANK_W +: BANK_W]) < NUM_BANKS;
   end

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++)
         for (int r = 0; r < NUM_REQ; r++)
            w_bank_req[b][r] = bus.req_valid[r] & w_in_range[r] &
                               (bus.req_bank[r*BANK_W +: BANK_W] == BANK_W'(b));
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      assign w_bank_adv[b] = |w_bank_req[b];

      rr_arbiter #(.N(NUM_REQ)) u_rr (
         .clk   (clk),
         .rst   (rst),
         .req   (w_bank_req[b]),
         .adv   (w_bank_adv[b]),
         .grant (w_bank_gnt[b])
      );
   end

   // Out-of-range requests are accepted at once so they never stall the requester.
   always_comb begin
      w_granted = '0;
      for (int b = 0; b < NUM_BANKS; b++)
         w_granted = w_granted | w_bank_gnt[b];
      bus.req_ready = rst ? (w_granted | (bus.req_valid & ~w_in_range)) : '0;
   end

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         w_win_id[b]    = '0;
         w_win_we[b]    = 1'b0;
         w_win_addr[b]  = '0;
         w_win_wdata[b] = '0;
         for (int r = 0; r < NUM_REQ; r++) begin
            if (w_bank_gnt[b][r]) begin
               w_win_id[b]    = ID_W'(r);
               w_win_we[b]    = bus.req_we[r];
               w_win_addr[b]  = bus.req_addr[r*ADDR_W +: ADDR_W];
               w_win_wdata[b] = bus.req_wdata[r*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_en     <= '0;
         r_we     <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_tag1_v <= '0;
         r_tag2_v <= '0;
         r_err1   <= '0;
         r_err2   <= '0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            r_tag1_id[b] <= '0;
            r_tag2_id[b] <= '0;
         end
      end else begin
         r_err1   <= bus.req_valid & ~w_in_range & ~bus.req_we;
         r_err2   <= r_err1;
         r_tag2_v <= r_tag1_v;
         for (int b = 0; b < NUM_BANKS; b++) begin
            r_en[b]      <= w_bank_adv[b];
            r_tag1_v[b]  <= w_bank_adv[b] & ~w_win_we[b];
            r_tag2_id[b] <= r_tag1_id[b];
            if (w_bank_adv[b]) begin
               r_we[b]                       <= w_win_we[b];
               r_addr[b*ADDR_W +: ADDR_W]    <= w_win_addr[b];
               r_wdata[b*DATA_W +: DATA_W]   <= w_win_wdata[b];
               r_tag1_id[b]                  <= w_win_id[b];
            end
         end
      end
   end

   assign sram_en    = r_en;
   assign sram_we    = r_we;
   assign sram_addr  = r_addr;
   assign sram_wdata = r_wdata;

   // Each requester issues at most once per cycle, so at most one source drives a response lane.
   always_comb begin
      w_rsp_valid = r_err2;
      w_rsp_rdata = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            if (r_tag2_v[b] && (r_tag2_id[b] == ID_W'(r))) begin
               w_rsp_valid[r]                    = 1'b1;
               w_rsp_rdata[r*RDATA_W +: RDATA_W] = sram_rdata[b*RDATA_W +: RDATA_W];
            end
         end
      end
   end

   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_err   = r_err2;
   assign bus.rsp_rdata = w_rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_sram_bank_arbiter.sv
// ============================================================================
// tb_sram_bank_arbiter
// Directed vectors with a response scoreboard; a 4-bank and a 3-bank instance.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_bank_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          dut;
      int          req;
      int          due;
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];

   logic [2:0]   t_valid [2];
   logic [2:0]   t_we    [2];
   logic [5:0]   t_bank  [2];
   logic [47:0]  t_addr  [2];
   logic [191:0] t_wdata [2];

   sram_bank_arbiter_if #(.NUM_REQ(3), .NUM_BANKS(4), .ADDR_W(16), .DATA_W(64), .RDATA_W(64)) bus_a ();
   sram_bank_arbiter_if #(.NUM_REQ(3), .NUM_BANKS(3), .ADDR_W(16), .DATA_W(64), .RDATA_W(64)) bus_b ();

   assign bus_a.req_valid = t_valid[0];
   assign bus_a.req_we    = t_we[0];
   assign bus_a.req_bank  = t_bank[0];
   assign bus_a.req_addr  = t_addr[0];
   assign bus_a.req_wdata = t_wdata[0];
   assign bus_b.req_valid = t_valid[1];
   assign bus_b.req_we    = t_we[1];
   assign bus_b.req_bank  = t_bank[1];
   assign bus_b.req_addr  = t_addr[1];
   assign bus_b.req_wdata = t_wdata[1];

   logic [3:0]   en_a, we_a;
   logic [63:0]  addr_a;
   logic [255:0] wdata_a, rdata_a;
   logic [2:0]   en_b, we_b;
   logic [47:0]  addr_b;
   logic [191:0] wdata_b, rdata_b;

   sram_bank_arbiter #(.NUM_REQ(3), .NUM_BANKS(4), .ADDR_W(16), .DATA_W(64), .RDATA_W(64)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a),
      .sram_en(en_a), .sram_we(we_a), .sram_addr(addr_a),
      .sram_wdata(wdata_a), .sram_rdata(rdata_a)
   );

   sram_bank_arbiter #(.NUM_REQ(3), .NUM_BANKS(3), .ADDR_W(16), .DATA_W(64), .RDATA_W(64)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b),
      .sram_en(en_b), .sram_we(we_b), .sram_addr(addr_b),
      .sram_wdata(wdata_b), .sram_rdata(rdata_b)
   );

   // SRAM array model: one-cycle registered read, preloaded on the first edge.
   logic [63:0] mem_a [4][256];
   logic [63:0] mem_b [3][256];

   always @(posedge clk) begin
      if (cyc == 0) begin
         for (int b = 0; b < 4; b++)
            for (int k = 0; k < 256; k++) mem_a[b][k] <= 64'h0;
         for (int b = 0; b < 3; b++)
            for (int k = 0; k < 256; k++) mem_b[b][k] <= 64'h0;
         mem_a[2][8'h10] <= 64'hAB;
         mem_a[1][8'h20] <= 64'h1111;
         mem_a[1][8'h21] <= 64'h2222;
         mem_a[1][8'h22] <= 64'h3333;
         mem_a[3][8'h07] <= 64'h77;
         mem_b[2][8'h01] <= 64'hB2;
         rdata_a <= '0;
         rdata_b <= '0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (en_a[b]) begin
               if (we_a[b]) mem_a[b][addr_a[b*16 +: 8]] <= wdata_a[b*64 +: 64];
               else         rdata_a[b*64 +: 64]         <= mem_a[b][addr_a[b*16 +: 8]];
            end
         for (int b = 0; b < 3; b++)
            if (en_b[b]) begin
               if (we_b[b]) mem_b[b][addr_b[b*16 +: 8]] <= wdata_b[b*64 +: 64];
               else         rdata_b[b*64 +: 64]         <= mem_b[b][addr_b[b*16 +: 8]];
            end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
      end
   endtask

   task automatic expect_rsp(input int d, input int r, input logic [63:0] rd, input logic e);
      exp_t x;
      x.dut = d; x.req = r; x.due = cyc + 2; x.rdata = rd; x.err = e;
      sb.push_back(x);
   endtask

   task automatic drive(input int d, input int r, input logic we, input int bank,
                        input int addr, input logic [63:0] wd);
      t_valid[d][r]           = 1'b1;
      t_we[d][r]              = we;
      t_bank[d][r*2 +: 2]     = 2'(bank);
      t_addr[d][r*16 +: 16]   = 16'(addr);
      t_wdata[d][r*64 +: 64]  = wd;
   endtask

   task automatic idle_all();
      for (int d = 0; d < 2; d++) begin
         t_valid[d] = '0; t_we[d] = '0; t_bank[d] = '0; t_addr[d] = '0; t_wdata[d] = '0;
      end
   endtask

   task automatic mon(input int d, input logic [2:0] v, input logic [2:0] e, input logic [191:0] rd);
      int idx;
      for (int r = 0; r < 3; r++) begin
         if (v[r] === 1'b1) begin
            idx = -1;
            for (int k = 0; k < sb.size(); k++)
               if (idx < 0 && sb[k].dut == d && sb[k].req == r) idx = k;
            checks++;
            if (idx < 0) begin
               errors++;
               $display("FAIL unexpected_rsp dut%0d r%0d cycle %0d: got rsp_valid=1, required 0", d, r, cyc);
            end else begin
               if (sb[idx].due != cyc || sb[idx].rdata !== rd[r*64 +: 64] || sb[idx].err !== e[r]) begin
                  errors++;
                  $display("FAIL rsp dut%0d r%0d: got cycle %0d rdata %0h err %0b, required cycle %0d rdata %0h err %0b",
                           d, r, cyc, rd[r*64 +: 64], e[r], sb[idx].due, sb[idx].rdata, sb[idx].err);
               end
               sb.delete(idx);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, bus_a.rsp_valid, bus_a.rsp_err, bus_a.rsp_rdata);
      mon(1, bus_b.rsp_valid, bus_b.rsp_err, bus_b.rsp_rdata);
      for (int k = sb.size() - 1; k >= 0; k--) begin
         if (sb[k].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_rsp dut%0d r%0d: got no response, required one at cycle %0d",
                     sb[k].dut, sb[k].req, sb[k].due);
            sb.delete(k);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] exp_g;
      rst = 1'b0;
      idle_all();

      // reset holds everything quiet even with every requester asking
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         for (int r = 0; r < 3; r++) begin
            drive(0, r, 1'b0, 0, r, 64'h0);
            drive(1, r, 1'b0, 1, r, 64'h0);
         end
         #1;
         chk("reset_ready_a", 64'(bus_a.req_ready), 64'h0);
         chk("reset_ready_b", 64'(bus_b.req_ready), 64'h0);
         chk("reset_en_a", 64'(en_a), 64'h0);
         chk("reset_rsp_a", 64'(bus_a.rsp_valid), 64'h0);
      end
      @(negedge clk);
      idle_all();
      rst = 1'b1;
      @(negedge clk);

      // single read
      drive(0, 0, 1'b0, 2, 'h10, 64'h0);
      #1;
      chk("single_ready", 64'(bus_a.req_ready), 64'h1);
      expect_rsp(0, 0, 64'hAB, 1'b0);
      @(negedge clk);
      idle_all();
      #1;
      chk("single_en", 64'(en_a), 64'h4);
      chk("single_we", 64'(we_a), 64'h0);
      chk("single_addr", 64'(addr_a[2*16 +: 16]), 64'h10);
      repeat (3) @(negedge clk);

      // three-way conflict on bank 1
      for (int r = 0; r < 3; r++) drive(0, r, 1'b0, 1, 'h20 + r, 64'h0);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         exp_g = 3'(1 << (i % 3));
         chk("conflict_ready", 64'(bus_a.req_ready), 64'(exp_g));
         expect_rsp(0, i % 3, 64'h1111 * ((i % 3) + 1), 1'b0);
      end
      @(negedge clk);
      idle_all();
      repeat (3) @(negedge clk);

      // parallel banks
      drive(0, 0, 1'b1, 0, 5, 64'h55);
      drive(0, 1, 1'b1, 1, 6, 64'h66);
      drive(0, 2, 1'b0, 3, 7, 64'h0);
      #1;
      chk("parallel_ready", 64'(bus_a.req_ready), 64'h7);
      expect_rsp(0, 2, 64'h77, 1'b0);
      @(negedge clk);
      idle_all();
      #1;
      chk("parallel_en", 64'(en_a), 64'hB);
      chk("parallel_we", 64'(we_a), 64'h3);
      chk("parallel_wdata1", wdata_a[1*64 +: 64], 64'h66);
      @(negedge clk);
      drive(0, 0, 1'b0, 0, 5, 64'h0);
      #1;
      chk("readback_ready", 64'(bus_a.req_ready), 64'h1);
      expect_rsp(0, 0, 64'h55, 1'b0);
      @(negedge clk);
      idle_all();
      repeat (3) @(negedge clk);

      // out-of-range bank on the 3-bank instance
      drive(1, 1, 1'b0, 3, 'h30, 64'h0);
      #1;
      chk("badbank_ready", 64'(bus_b.req_ready), 64'h2);
      expect_rsp(1, 1, 64'h0, 1'b1);
      @(negedge clk);
      idle_all();
      #1;
      chk("badbank_en", 64'(en_b), 64'h0);
      @(negedge clk);
      drive(1, 0, 1'b0, 2, 1, 64'h0);
      drive(1, 1, 1'b0, 3, 'h30, 64'h0);
      drive(1, 2, 1'b1, 3, 'h31, 64'h99);
      #1;
      chk("mixed_ready_b", 64'(bus_b.req_ready), 64'h7);
      expect_rsp(1, 0, 64'hB2, 1'b0);
      expect_rsp(1, 1, 64'h0, 1'b1);
      @(negedge clk);
      idle_all();
      #1;
      chk("mixed_en_b", 64'(en_b), 64'h4);
      repeat (3) @(negedge clk);

      // reset while two reads are in flight
      drive(0, 0, 1'b0, 0, 5, 64'h0);
      drive(0, 1, 1'b0, 1, 6, 64'h0);
      #1;
      chk("midrst_ready", 64'(bus_a.req_ready), 64'h3);
      @(negedge clk);
      idle_all();
      rst = 1'b0;
      #1;
      chk("midrst_en", 64'(en_a), 64'h3);
      @(negedge clk);
      #1;
      chk("midrst_rsp", 64'(bus_a.rsp_valid), 64'h0);
      chk("midrst_en_cleared", 64'(en_a), 64'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("postrst_rsp", 64'(bus_a.rsp_valid), 64'h0);
      @(negedge clk);
      for (int r = 0; r < 3; r++) drive(0, r, 1'b0, 1, 'h20 + r, 64'h0);
      #1;
      chk("postrst_grant", 64'(bus_a.req_ready), 64'h1);
      expect_rsp(0, 0, 64'h1111, 1'b0);
      @(negedge clk);
      idle_all();
      repeat (5) @(negedge clk);
      #1;
      chk("scoreboard_drained", 64'(sb.size()), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
